// File: rtl/mem_access_arbiter_pkg.sv
// Shared types for the round-robin memory access arbiter.
package mem_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_RESP_OK       = 1'b0,
    ARB_RESP_ADDR_ERR = 1'b1
  } arb_resp_e;

  localparam int unsigned ARB_DEFAULT_DEPTH = 256;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin selector: first valid requester after ptr, with wrap.
module mem_arb_rr_pick
  import mem_access_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_valid
);

  always_comb begin : pick
    int unsigned cand;
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    cand      = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(ptr) + i) % NUM_REQ;
      if (!any_valid && valid[IDX_W'(cand)]) begin
        any_valid              = 1'b1;
        idx                    = IDX_W'(cand);
        grant[IDX_W'(cand)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one single-port word RAM between NUM_REQ requesters.
// Optional address range check: define MEM_ACCESS_ARBITER_ADDR_CHECK_EN.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = ARB_DEFAULT_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ-1:0]          req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_be_i,
  output logic [NUM_REQ-1:0]          resp_valid_o,
  output logic [DATA_W-1:0]           resp_rdata_o,
  output logic                        resp_err_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_data_o,
  output logic [DATA_W/8-1:0]         mem_be_o,
  output logic                        mem_we_o,
  input  logic [DATA_W-1:0]           mem_q_i
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state, state_nxt;
  logic                accept;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0]  pick_grant;
  logic                pick_any;
  logic [NUM_REQ-1:0]  lat_grant;
  logic                lat_we;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [BE_W-1:0]     sel_be;

  mem_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid     (req_valid_i),
    .ptr       (rr_ptr),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  // Payload of the currently selected requester
  assign sel_we    = req_we_i[pick_idx];
  assign sel_addr  = req_addr_i[32'(pick_idx) * ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata_i[32'(pick_idx) * DATA_W +: DATA_W];
  assign sel_be    = req_be_i[32'(pick_idx) * BE_W +: BE_W];

`ifdef MEM_ACCESS_ARBITER_ADDR_CHECK_EN
  logic      sel_in_range;
  arb_resp_e lat_status;
  assign sel_in_range = (sel_addr < ADDR_W'(DEPTH));
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; acceptance happens only in IDLE
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          accept    = 1'b1;
          state_nxt = ARB_ISSUE;
        end
      end
      ARB_ISSUE: state_nxt = ARB_RESP;
      ARB_RESP:  state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  assign req_ready_o = accept ? pick_grant : '0;

  // Request latch, memory port and response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr       <= IDX_W'(NUM_REQ - 1);
      lat_grant    <= '0;
      lat_we       <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      mem_be_o     <= '0;
      mem_we_o     <= 1'b0;
      resp_valid_o <= '0;
      resp_rdata_o <= '0;
`ifdef MEM_ACCESS_ARBITER_ADDR_CHECK_EN
      lat_status   <= ARB_RESP_OK;
      resp_err_o   <= 1'b0;
`endif
    end else begin
      resp_valid_o <= '0;
      mem_we_o     <= 1'b0;
`ifdef MEM_ACCESS_ARBITER_ADDR_CHECK_EN
      resp_err_o   <= 1'b0;
`endif
      if (accept) begin
        rr_ptr     <= pick_idx;
        lat_grant  <= pick_grant;
        lat_we     <= sel_we;
        mem_addr_o <= sel_addr;
        mem_data_o <= sel_wdata;
        mem_be_o   <= sel_be;
`ifdef MEM_ACCESS_ARBITER_ADDR_CHECK_EN
        mem_we_o   <= sel_we & sel_in_range;
        lat_status <= sel_in_range ? ARB_RESP_OK : ARB_RESP_ADDR_ERR;
`else
        mem_we_o   <= sel_we;
`endif
      end
      if (state == ARB_RESP) begin
        resp_valid_o <= lat_grant;
`ifdef MEM_ACCESS_ARBITER_ADDR_CHECK_EN
        if (lat_status == ARB_RESP_ADDR_ERR) begin
          resp_rdata_o <= '0;
          resp_err_o   <= 1'b1;
        end else if (!lat_we) begin
          resp_rdata_o <= mem_q_i;
        end
`else
        if (!lat_we) begin
          resp_rdata_o <= mem_q_i;
        end
`endif
      end
    end
  end

`ifndef MEM_ACCESS_ARBITER_ADDR_CHECK_EN
  assign resp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a behavioural single-port RAM.
`timescale 1ns/1ps
module tb_mem_access_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned DEPTH   = 256;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid, req_ready, req_we, resp_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ*BE_W-1:0]   req_be;
  logic [DATA_W-1:0]         resp_rdata, mem_data, mem_q;
  logic                      resp_err, mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [BE_W-1:0]           mem_be;
  logic [DATA_W-1:0]         ram [DEPTH];

  int checks    = 0;
  int failures  = 0;
  int we_pulses = 0;

  always #5 clk = ~clk;

  mem_access_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_be_i     (req_be),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_data),
    .mem_be_o     (mem_be),
    .mem_we_o     (mem_we),
    .mem_q_i      (mem_q)
  );

  // Single-port RAM: registered read address, one-cycle read latency
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(BE_W); b++)
        if (mem_be[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_data[8*b +: 8];
      we_pulses <= we_pulses + 1;
    end
    mem_q <= ram[mem_addr[7:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [1:0] k, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be,
                         output logic [NUM_REQ-1:0] ready_seen, output logic [NUM_REQ-1:0] resp_seen,
                         output logic [DATA_W-1:0] rdata, output logic err, output int lat);
    req_we[k] = we;
    req_addr[32'(k)*ADDR_W +: ADDR_W]   = addr;
    req_wdata[32'(k)*DATA_W +: DATA_W]  = wdata;
    req_be[32'(k)*BE_W +: BE_W]         = be;
    req_valid[k] = 1'b1;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (req_ready != '0) break;
      tick();
    end
    ready_seen = req_ready;
    tick();
    req_valid[k] = 1'b0;
    lat = 1;
    for (int c = 0; c < 20 && resp_valid == '0; c++) begin
      tick();
      lat++;
    end
    resp_seen = resp_valid;
    rdata     = resp_rdata;
    err       = resp_err;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (resp_valid !== '0) begin failures++; $display("FAIL reset_resp_valid: got %b expected 0000", resp_valid); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (resp_rdata !== '0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", resp_err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic [NUM_REQ-1:0] rs, rv;
    logic [DATA_W-1:0] rd;
    logic er;
    int lat;
    run_txn(2'd0, 1'b1, 32'd5, 32'hDEADBEEF, 4'hF, rs, rv, rd, er, lat);
    checks++; if (rs !== 4'b0001) begin failures++; $display("FAIL wr_ready: got %b expected 0001", rs); end
    checks++; if (rv !== 4'b0001) begin failures++; $display("FAIL wr_resp: got %b expected 0001", rv); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    run_txn(2'd0, 1'b0, 32'd5, 32'h0, 4'h0, rs, rv, rd, er, lat);
    checks++; if (rv !== 4'b0001) begin failures++; $display("FAIL rd_resp: got %b expected 0001", rv); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL rd_err: got %b expected 0", er); end
  endtask

  task automatic test_byte_enables();
    logic [NUM_REQ-1:0] rs, rv;
    logic [DATA_W-1:0] rd;
    logic er;
    int lat;
    run_txn(2'd1, 1'b1, 32'd7, 32'h11223344, 4'hF, rs, rv, rd, er, lat);
    checks++; if (rv !== 4'b0010) begin failures++; $display("FAIL be_init_resp: got %b expected 0010", rv); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rdata_hold: got %h expected deadbeef", rd); end
    run_txn(2'd1, 1'b1, 32'd7, 32'hAABBCCDD, 4'b0101, rs, rv, rd, er, lat);
    run_txn(2'd1, 1'b0, 32'd7, 32'h0, 4'h0, rs, rv, rd, er, lat);
    checks++; if (rv !== 4'b0010) begin failures++; $display("FAIL be_read_resp: got %b expected 0010", rv); end
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL be_merge: got %h expected 11bb33dd", rd); end
  endtask

  task automatic test_contention();
    logic [NUM_REQ-1:0] g, exp_ready, exp_resp;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      req_we[k] = 1'b0;
      req_addr[k*ADDR_W +: ADDR_W] = 32'd5;
    end
    req_valid = 4'hF;
    tick();
    rst_n = 1'b1;
    #1;
    for (int c = 0; c <= 12; c++) begin
      exp_ready = (c % 3 == 0 && c < 12) ? 4'(1 << (c / 3)) : 4'b0000;
      exp_resp  = (c % 3 == 0 && c > 0)  ? 4'(1 << (c / 3 - 1)) : 4'b0000;
      checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL contention_ready c=%0d: got %b expected %b", c, req_ready, exp_ready); end
      checks++; if (resp_valid !== exp_resp) begin failures++; $display("FAIL contention_resp c=%0d: got %b expected %b", c, resp_valid, exp_resp); end
      if (exp_resp != '0) begin
        checks++; if (resp_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL contention_rdata c=%0d: got %h expected deadbeef", c, resp_rdata); end
      end
      g = req_ready;
      tick();
      req_valid = req_valid & ~g;
      #1;
    end
    req_valid = '0;
  endtask

  task automatic test_fairness();
    logic [1:0] g, last;
    logic has_last;
    int others_since2, count2;
    has_last = 1'b0; last = 2'd0; others_since2 = 0; count2 = 0;
    req_we = '0;
    req_valid = 4'hF;
    #1;
    for (int c = 0; c < 24; c++) begin
      checks++; if ((req_ready & (req_ready - 4'd1)) !== 4'b0000) begin failures++; $display("FAIL fair_onehot c=%0d: got %b expected at most one bit", c, req_ready); end
      if (req_ready != '0) begin
        g = 2'd0;
        for (int k = 0; k < int'(NUM_REQ); k++) if (req_ready[k]) g = 2'(k);
        if (has_last) begin
          checks++; if (g !== 2'(last + 2'd1)) begin failures++; $display("FAIL fair_rotation c=%0d: got %0d expected %0d", c, g, 2'(last + 2'd1)); end
        end
        if (g == 2'd2) begin
          count2++;
          others_since2 = 0;
        end else begin
          others_since2++;
          checks++; if (others_since2 > 3) begin failures++; $display("FAIL fair_starve c=%0d: got %0d other grants expected <= 3", c, others_since2); end
        end
        last = g; has_last = 1'b1;
      end
      tick();
    end
    checks++; if (count2 !== 2) begin failures++; $display("FAIL fair_count2: got %0d expected 2", count2); end
    req_valid = '0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_op();
    logic [NUM_REQ-1:0] rs, rv, seen, g;
    logic [DATA_W-1:0] rd, rd0;
    logic er;
    int lat;
    run_txn(2'd0, 1'b1, 32'd9, 32'hCAFEF00D, 4'hF, rs, rv, rd, er, lat);
    req_we[0] = 1'b1;
    req_addr[0 +: ADDR_W] = 32'd9;
    req_wdata[0 +: DATA_W] = 32'h12345678;
    req_be[0 +: BE_W] = 4'hF;
    req_valid[0] = 1'b1;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (req_ready != '0) break;
      tick();
    end
    tick();
    req_valid = '0;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL mid_issue_we: got %b expected 1", mem_we); end
    checks++; if (mem_addr !== 32'd9) begin failures++; $display("FAIL mid_issue_addr: got %h expected 9", mem_addr); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL mid_async_we: got %b expected 0", mem_we); end
    tick();
    checks++; if (ram[9] !== 32'hCAFEF00D) begin failures++; $display("FAIL mid_ram_unchanged: got %h expected cafef00d", ram[9]); end
    rst_n = 1'b1;
    seen = '0;
    for (int c = 0; c < 5; c++) begin
      seen = seen | resp_valid;
      tick();
    end
    checks++; if (seen !== 4'b0000) begin failures++; $display("FAIL mid_no_resp: got %b expected 0000", seen); end
    req_we = '0;
    req_addr[0 +: ADDR_W] = 32'd9;
    req_addr[3*ADDR_W +: ADDR_W] = 32'd9;
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready); end
    rd0 = '0;
    for (int c = 0; c < 12; c++) begin
      g = req_ready;
      tick();
      req_valid = req_valid & ~g;
      if (resp_valid[0]) rd0 = resp_rdata;
      #1;
    end
    checks++; if (rd0 !== 32'hCAFEF00D) begin failures++; $display("FAIL mid_readback: got %h expected cafef00d", rd0); end
    req_valid = '0;
    repeat (4) tick();
  endtask

  task automatic test_addr_check();
    logic [NUM_REQ-1:0] rs, rv;
    logic [DATA_W-1:0] rd;
    logic er;
    int lat;
`ifdef MEM_ACCESS_ARBITER_ADDR_CHECK_EN
    int pulses0;
    logic [DATA_W-1:0] snap;
    run_txn(2'd0, 1'b0, 32'd300, 32'h0, 4'h0, rs, rv, rd, er, lat);
    checks++; if (rv !== 4'b0001) begin failures++; $display("FAIL chk300_resp: got %b expected 0001", rv); end
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL chk300_err: got %b expected 1", er); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL chk300_rdata: got %h expected 0", rd); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL chk_err_idle: got %b expected 0", resp_err); end
    pulses0 = we_pulses;
    snap = ram[0];
    run_txn(2'd2, 1'b1, 32'd256, 32'hFFFFFFFF, 4'hF, rs, rv, rd, er, lat);
    checks++; if (we_pulses !== pulses0) begin failures++; $display("FAIL chk256_we: got %0d pulses expected %0d", we_pulses, pulses0); end
    checks++; if (ram[0] !== snap) begin failures++; $display("FAIL chk256_ram: got %h expected %h", ram[0], snap); end
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL chk256_err: got %b expected 1", er); end
    run_txn(2'd1, 1'b1, 32'd255, 32'h00C0FFEE, 4'hF, rs, rv, rd, er, lat);
    run_txn(2'd1, 1'b0, 32'd255, 32'h0, 4'h0, rs, rv, rd, er, lat);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL chk255_err: got %b expected 0", er); end
    checks++; if (rd !== 32'h00C0FFEE) begin failures++; $display("FAIL chk255_rdata: got %h expected 00c0ffee", rd); end
`else
    run_txn(2'd0, 1'b0, 32'd300, 32'h0, 4'h0, rs, rv, rd, er, lat);
    checks++; if (rv !== 4'b0001) begin failures++; $display("FAIL nochk300_resp: got %b expected 0001", rv); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL nochk300_err: got %b expected 0", er); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL nochk300_latency: got %0d expected 3", lat); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_contention();
    test_fairness();
    test_reset_mid_op();
    test_addr_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
